// File: rtl/shake_arbiter.sv
// Round-robin owner arbiter sharing one SHAKE256 core between NUM_REQ requesters for whole sessions.
// Optional idle-handshake watchdog enabled by defining SHAKE_ARB_TIMEOUT_EN.
module shake_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int LOG_REQ        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [LOG_REQ-1:0]      owner,
  output logic                    busy,
  input  logic [NUM_REQ-1:0]      r_din_valid,
  input  logic [32*NUM_REQ-1:0]   r_din,
  output logic [NUM_REQ-1:0]      r_din_ready,
  output logic [NUM_REQ-1:0]      r_dout_valid,
  input  logic [NUM_REQ-1:0]      r_dout_ready,
  output logic [31:0]             r_dout,
  input  logic [NUM_REQ-1:0]      r_force_done,
  output logic                    shake_din_valid,
  input  logic                    shake_din_ready,
  output logic [31:0]             shake_din,
  input  logic                    shake_dout_valid,
  output logic                    shake_dout_ready,
  input  logic [31:0]             shake_dout_scram,
  output logic                    shake_force_done,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [NUM_REQ-1:0]   gnt_nxt_s;
  logic [LOG_REQ-1:0]   owner_nxt_s;
  logic                 busy_nxt_s;
  logic [LOG_REQ-1:0]   rr_last_r;
  logic [LOG_REQ-1:0]   rr_nxt_s;
  logic                 found_s;
  logic [LOG_REQ-1:0]   pick_s;
  logic                 own_req_s;
  logic                 own_force_s;
  logic                 timeout_hit_s;

  assign r_dout = shake_dout_scram;

  // Round-robin pick: first requester after rr_last_r, wrapping.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {LOG_REQ{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found_s && req[i] && (i == ((int'(rr_last_r) + k) % NUM_REQ))) begin
          found_s = 1'b1;
          pick_s  = LOG_REQ'(i);
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Combinational handshake routing between the owner and the core.
  always_comb begin
    shake_din_valid  = 1'b0;
    shake_din        = 32'd0;
    shake_dout_ready = 1'b0;
    r_din_ready      = {NUM_REQ{1'b0}};
    r_dout_valid     = {NUM_REQ{1'b0}};
    own_req_s        = 1'b0;
    own_force_s      = 1'b0;
    if (state_r == OWNED) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner == LOG_REQ'(i)) begin
          shake_din_valid  = r_din_valid[i];
          shake_din        = r_din[32*i +: 32];
          r_din_ready[i]   = shake_din_ready;
          r_dout_valid[i]  = shake_dout_valid;
          shake_dout_ready = r_dout_ready[i];
          own_req_s        = req[i];
          own_force_s      = r_force_done[i];
        end else begin
          r_din_ready[i]   = 1'b0;
        end
      end
    end else begin
      own_req_s = 1'b0;
    end
  end

  // A dropped request is treated as an abort, so the core is told to finish.
  assign shake_force_done = (state_r == OWNED) &&
                            (own_force_s || !own_req_s || timeout_hit_s);

  // Next-state and next-grant logic.
  always_comb begin
    state_nxt_s = state_r;
    gnt_nxt_s   = gnt;
    owner_nxt_s = owner;
    busy_nxt_s  = busy;
    rr_nxt_s    = rr_last_r;
    case (state_r)
      IDLE, RELEASE: begin
        if (found_s) begin
          gnt_nxt_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
          owner_nxt_s = pick_s;
          busy_nxt_s  = 1'b1;
          state_nxt_s = OWNED;
        end else begin
          gnt_nxt_s   = {NUM_REQ{1'b0}};
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end
      end
      OWNED: begin
        if (shake_force_done) begin
          rr_nxt_s    = owner;
          gnt_nxt_s   = {NUM_REQ{1'b0}};
          busy_nxt_s  = 1'b0;
          state_nxt_s = RELEASE;
        end else begin
          state_nxt_s = OWNED;
        end
      end
      default: begin
        gnt_nxt_s   = {NUM_REQ{1'b0}};
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      gnt       <= {NUM_REQ{1'b0}};
      owner     <= {LOG_REQ{1'b0}};
      busy      <= 1'b0;
      rr_last_r <= LOG_REQ'(NUM_REQ - 1);
    end else begin
      state_r   <= state_nxt_s;
      gnt       <= gnt_nxt_s;
      owner     <= owner_nxt_s;
      busy      <= busy_nxt_s;
      rr_last_r <= rr_nxt_s;
    end
  end

`ifdef SHAKE_ARB_TIMEOUT_EN
  logic [12:0] wd_cnt_r;
  logic        timeout_err_r;
  logic        hs_s;

  assign hs_s = (shake_din_valid && shake_din_ready) ||
                (shake_dout_valid && shake_dout_ready);
  assign timeout_hit_s = (state_r == OWNED) && !hs_s &&
                         (wd_cnt_r == 13'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_r;

  // Watchdog counts consecutive stalled OWNED cycles; error flag is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r      <= 13'd0;
      timeout_err_r <= 1'b0;
    end else begin
      if ((state_r != OWNED) || hs_s) begin
        wd_cnt_r <= 13'd0;
      end else begin
        wd_cnt_r <= wd_cnt_r + 13'd1;
      end
      if (timeout_hit_s) begin
        timeout_err_r <= 1'b1;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_shake_arbiter.sv
// Directed self-checking bench for shake_arbiter with two requesters.
module tb_shake_arbiter;
`ifdef SHAKE_ARB_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, gnt;
  logic [0:0]  owner;
  logic        busy;
  logic [1:0]  r_din_valid, r_din_ready, r_dout_valid, r_dout_ready, r_force_done;
  logic [63:0] r_din;
  logic [31:0] r_dout, shake_din, shake_dout_scram;
  logic        shake_din_valid, shake_din_ready, shake_dout_valid, shake_dout_ready;
  logic        shake_force_done, timeout_err;

  int total = 0;
  int bad   = 0;
  int hs_cnt;
  int early;
  logic [5:0] rdy_pat;

  shake_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .owner(owner), .busy(busy),
    .r_din_valid(r_din_valid), .r_din(r_din), .r_din_ready(r_din_ready),
    .r_dout_valid(r_dout_valid), .r_dout_ready(r_dout_ready), .r_dout(r_dout),
    .r_force_done(r_force_done),
    .shake_din_valid(shake_din_valid), .shake_din_ready(shake_din_ready),
    .shake_din(shake_din), .shake_dout_valid(shake_dout_valid),
    .shake_dout_ready(shake_dout_ready), .shake_dout_scram(shake_dout_scram),
    .shake_force_done(shake_force_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; r_din_valid = 2'b00; r_din = 64'd0;
    r_dout_ready = 2'b00; r_force_done = 2'b00;
    shake_din_ready = 1'b0; shake_dout_valid = 1'b0; shake_dout_scram = 32'd0;
    #1;
    chk("rst_gnt", {62'd0, gnt}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_owner", {63'd0, owner}, 64'd0);
    chk("rst_core", {60'd0, shake_din_valid, shake_dout_ready, shake_force_done, timeout_err}, 64'd0);
    chk("rst_rdy", {60'd0, r_din_ready, r_dout_valid}, 64'd0);
    tick(); tick();
    rst = 1'b0;

    // Single requester, 17-word absorb.
    req = 2'b01;
    tick();
    chk("t1_gnt", {62'd0, gnt}, 64'h1);
    chk("t1_owner_busy", {62'd0, owner, busy}, 64'h1);
    shake_din_ready = 1'b1;
    r_din_valid = 2'b01;
    for (int i = 0; i < 17; i++) begin
      r_din = {32'hDEAD0000 + 32'(i), 32'hA5000000 + 32'(i)};
      #1;
      chk("t1_word", {31'd0, shake_din_valid, shake_din}, {31'd0, 1'b1, 32'hA5000000 + 32'(i)});
      chk("t1_rdy", {62'd0, r_din_ready}, 64'h1);
      tick();
    end
    r_din_valid = 2'b00;
    shake_din_ready = 1'b0;
    // Force_done with req still high: released, then re-granted as sole requester.
    r_force_done = 2'b01;
    #1;
    chk("t1_fd", {63'd0, shake_force_done}, 64'h1);
    tick();
    r_force_done = 2'b00;
    chk("t1_rel", {61'd0, gnt, busy}, 64'd0);
    tick();
    chk("t1_regnt", {61'd0, gnt, busy}, {61'd0, 2'b01, 1'b1});
    r_force_done = 2'b01; req = 2'b00;
    tick();
    r_force_done = 2'b00;
    tick();
    chk("t1_idle", {61'd0, gnt, busy}, 64'd0);

    // Simultaneous requests after reset, then hand-over with a one-cycle gap.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 2'b11;
    tick();
    chk("t2_first", {62'd0, gnt}, 64'h1);
    r_force_done = 2'b01;
    tick();
    r_force_done = 2'b00;
    chk("t2_gap", {61'd0, gnt, busy}, 64'd0);
    tick();
    chk("t2_second", {60'd0, gnt, owner, busy}, {60'd0, 2'b10, 1'b1, 1'b1});

    // Squeeze to owner 1 with toggling ready.
    shake_dout_valid = 1'b1;
    shake_dout_scram = 32'h40000740;
    rdy_pat = 6'b101101;
    hs_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      r_dout_ready = {rdy_pat[k], 1'b1};
      #1;
      chk("t3_dvalid", {62'd0, r_dout_valid}, 64'h2);
      chk("t3_dready", {63'd0, shake_dout_ready}, {63'd0, rdy_pat[k]});
      chk("t3_data", {32'd0, r_dout}, 64'h40000740);
      if (shake_dout_ready && shake_dout_valid) hs_cnt++;
      tick();
    end
    chk("t3_hs_count", 64'(hs_cnt), 64'd4);
    shake_dout_valid = 1'b0; r_dout_ready = 2'b00;
    // Non-owner force_done is ignored.
    r_force_done = 2'b01;
    #1;
    chk("t3_nonowner_fd", {63'd0, shake_force_done}, 64'd0);
    tick();
    r_force_done = 2'b00;
    chk("t3_still_owned", {61'd0, gnt, busy}, {61'd0, 2'b10, 1'b1});

    // Owner 1 aborts by dropping req mid-absorb.
    req = 2'b00; r_din_valid = 2'b10; shake_din_ready = 1'b1;
    #1;
    chk("t4_abort_fd", {63'd0, shake_force_done}, 64'h1);
    tick();
    chk("t4_release", {58'd0, gnt, busy, shake_din_valid, r_din_ready}, 64'd0);
    tick();
    chk("t4_idle", {61'd0, gnt, busy}, 64'd0);
    r_din_valid = 2'b00; shake_din_ready = 1'b0;

    // Round robin after owner 1 released, then async reset mid-squeeze.
    req = 2'b11;
    tick();
    chk("t5_rr", {62'd0, gnt}, 64'h1);
    shake_dout_valid = 1'b1; r_dout_ready = 2'b01;
    #1;
    chk("t5_dvalid", {62'd0, r_dout_valid}, 64'h1);
    rst = 1'b1;
    #1;
    chk("t5_async", {58'd0, gnt, busy, shake_dout_ready, r_dout_valid}, 64'd0);
    rst = 1'b0; req = 2'b10; shake_dout_valid = 1'b0; r_dout_ready = 2'b00;
    tick();
    chk("t5_regnt", {60'd0, gnt, owner, busy}, {60'd0, 2'b10, 1'b1, 1'b1});

    // Owner 1 stalls every handshake.
    early = 0;
`ifdef SHAKE_ARB_TIMEOUT_EN
    for (int n = 1; n < 16; n++) begin
      if (shake_force_done) early++;
      tick();
    end
    chk("t6_no_early", 64'(early), 64'd0);
    chk("t6_fd16", {62'd0, shake_force_done, timeout_err}, {62'd0, 1'b1, 1'b0});
    tick();
    chk("t6_err_set", {62'd0, timeout_err, busy}, {62'd0, 1'b1, 1'b0});
    tick();
    chk("t6_err_sticky", {62'd0, timeout_err, busy}, {62'd0, 1'b1, 1'b1});
`else
    for (int n = 0; n < 20; n++) begin
      if (shake_force_done) early++;
      tick();
    end
    chk("t6_no_fd", 64'(early), 64'd0);
    chk("t6_no_err", {62'd0, timeout_err, busy}, {62'd0, 1'b0, 1'b1});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
